// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM encoding, radix-4 Booth digit
// codes and the digit-count macro.

`define BOOTH_N(w) ((w) / 2 + 1)

package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 Booth digit codes (Q[2i+2:2i]) grouped by the multiple they select
    localparam logic [2:0] BD_ZERO_P = 3'b000;
    localparam logic [2:0] BD_P1_LO  = 3'b001;
    localparam logic [2:0] BD_P1_HI  = 3'b010;
    localparam logic [2:0] BD_P2     = 3'b011;
    localparam logic [2:0] BD_M2     = 3'b100;
    localparam logic [2:0] BD_M1_LO  = 3'b101;
    localparam logic [2:0] BD_M1_HI  = 3'b110;
    localparam logic [2:0] BD_ZERO_N = 3'b111;

endpackage

// File: rtl/booth_radix4_seq_multiplier_if.sv
// Operand/result handshake bundle of the sequential Booth multiplier.

interface booth_radix4_seq_multiplier_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           is_signed;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;

    // Requester / consumer side
    modport master (
        output in_valid, op1, op2, is_signed, flush, out_ready,
        input  in_ready, out_valid, result
    );

    // Multiplier side
    modport slave (
        input  in_valid, op1, op2, is_signed, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit to partial product (W+2 bits, two's complement).

module booth_r4_encoder
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   digit_i,
    input  logic [W+1:0] m_i,
    output logic [W+1:0] pp_o
);
    logic [W+1:0] m2;

    // 2M never overflows W+2 bits since M carries two guard bits
    assign m2 = {m_i[W:0], 1'b0};

    // Select 0, +-M or +-2M from the three overlapping multiplier bits
    always_comb begin
        pp_o = '0;
        case (digit_i)
            BD_ZERO_P, BD_ZERO_N: pp_o = '0;
            BD_P1_LO, BD_P1_HI:   pp_o = m_i;
            BD_P2:                pp_o = m2;
            BD_M2:                pp_o = -m2;
            BD_M1_LO, BD_M1_HI:   pp_o = -m_i;
            default:              pp_o = '0;
        endcase
    end
endmodule

// File: rtl/booth_radix4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one digit per clock, fixed N-cycle
// latency, valid/ready on both sides, synchronous flush.

module booth_radix4_seq_multiplier
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input logic                          clk,
    input logic                          rst_b,
    booth_radix4_seq_multiplier_if.slave bus
);
    localparam int N  = `BOOTH_N(W);
    localparam int CW = $clog2(N);
    localparam int AW = 2 * W + 4;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W+1:0]   m_q, m_d;
    logic [W+2:0]   q_q, q_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [2*W-1:0] result_q, result_d;

    logic [2:0]     digit;
    logic [W+1:0]   pp;
    logic [AW-1:0]  pp_shift;
    logic           ext_m;
    logic           ext_q;

    // Digit i sits at Q[2i+2:2i]; the shift keeps the read in range for any cnt
    assign digit    = 3'(q_q >> {cnt_q, 1'b0});
    assign pp_shift = {{(W + 2){pp[W+1]}}, pp} << {cnt_q, 1'b0};
    assign ext_m    = bus.is_signed & bus.op1[W-1];
    assign ext_q    = bus.is_signed & bus.op2[W-1];

    booth_r4_encoder #(.W(W)) u_enc (
        .digit_i (digit),
        .m_i     (m_q),
        .pp_o    (pp)
    );

    // Outputs are pure functions of state so in_ready is 0 for the whole DONE phase
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;

    // Next state: flush beats accept and the result handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.flush && bus.in_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    m_d     = {{2{ext_m}}, bus.op1};
                    q_d     = {{2{ext_q}}, bus.op2, 1'b0};
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + pp_shift;
                    cnt_d = cnt_q + 1'b1;
                    // Last digit always runs, even when it is 0 in signed mode
                    if (cnt_q == CW'(N - 1)) begin
                        state_d  = DONE;
                        result_d = acc_d[2*W-1:0];
                    end
                end
            end
            DONE: begin
                if (bus.flush || bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end
endmodule
